// File: rtl/clk_char_meter_pkg.sv
`timescale 1ns/1ps
// Shared types and default widths for the clock-characterisation meter.
// State encoding is local to the meter FSM; the defaults size the counters and limits.
package clk_char_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REF,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW,
    DONE
  } meas_state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_CYC_DEF = 1000;

endpackage

// File: rtl/clk_char_meter_edge_sync.sv
`timescale 1ns/1ps
// Synchronises an async input into clk and flags rising/falling edges.
// Latency: SYNC_STAGES flops then one delay flop; no backpressure, edges are single-cycle pulses.
module edge_sync
  import clk_char_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/clk_char_meter.sv
`timescale 1ns/1ps
// Measures phase (ref rise to sig rise), high, low and period of sig_in in clk cycles.
// Latency: wait-for-ref + phase + ton + toff + 2 cycles from start; no backpressure, start ignored while busy.
module clk_char_meter
  import clk_char_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  input  logic             ref_in,
  output logic             busy,
  output logic             valid,
  output logic             err,
  output logic [CNT_W-1:0] phase_cyc,
  output logic [CNT_W-1:0] ton_cyc,
  output logic [CNT_W-1:0] toff_cyc,
  output logic [CNT_W:0]   period_cyc
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic sig_rise, sig_fall, ref_rise, ref_fall_unused;

  meas_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] ph_lat_q, ph_lat_d, ton_lat_q, ton_lat_d;
  logic             busy_q, busy_d, valid_q, valid_d, err_q, err_d;
  logic [CNT_W-1:0] phase_q, phase_d, ton_q, ton_d, toff_q, toff_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             tmo, fin, fin_err;
  logic [CNT_W-1:0] fin_toff;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (sig_rise),
    .fall (sig_fall)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (ref_in),
    .rise (ref_rise),
    .fall (ref_fall_unused)
  );

  // Saturating count: timeout fires on the cycle the limit is reached, so it never wraps.
  assign tmo     = (cnt_q == TMO);
  assign cnt_inc = tmo ? cnt_q : cnt_q + ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    ph_lat_d  = ph_lat_q;
    ton_lat_d = ton_lat_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_toff  = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = WAIT_REF;
      end
      WAIT_REF: begin
        if (tmo) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (ref_rise) begin
          cnt_d    = ONE;
          ph_lat_d = '0;
          state_d  = sig_rise ? MEAS_HIGH : WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (tmo) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (sig_rise) begin
          ph_lat_d = cnt_q;
          cnt_d    = ONE;
          state_d  = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
        if (tmo) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (sig_fall) begin
          ton_lat_d = cnt_q;
          cnt_d     = ONE;
          state_d   = MEAS_LOW;
        end
      end
      MEAS_LOW: begin
        if (tmo) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (sig_rise) begin
          fin      = 1'b1;
          fin_toff = cnt_q;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fin) state_d = DONE;

    busy_d   = state_d inside {WAIT_REF, WAIT_RISE, MEAS_HIGH, MEAS_LOW};
    valid_d  = fin;
    err_d    = err_q;
    phase_d  = phase_q;
    ton_d    = ton_q;
    toff_d   = toff_q;
    period_d = period_q;
    if (fin) begin
      err_d    = fin_err;
      phase_d  = fin_err ? '0 : ph_lat_q;
      ton_d    = fin_err ? '0 : ton_lat_q;
      toff_d   = fin_toff;
      period_d = fin_err ? '0 : {1'b0, ton_lat_q} + {1'b0, fin_toff};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ph_lat_q  <= '0;
      ton_lat_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      phase_q   <= '0;
      ton_q     <= '0;
      toff_q    <= '0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph_lat_q  <= ph_lat_d;
      ton_lat_q <= ton_lat_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      phase_q   <= phase_d;
      ton_q     <= ton_d;
      toff_q    <= toff_d;
      period_q  <= period_d;
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign phase_cyc  = phase_q;
  assign ton_cyc    = ton_q;
  assign toff_cyc   = toff_q;
  assign period_cyc = period_q;

endmodule
